// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: opcodes, FSM encoding and
// the shift-amount width helper.
package iter_shifter_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_ROR = 2'b01;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic int shamt_w(input int data_width);
      return $clog2(data_width);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: shifts or rotates by the fixed distance DIST when enabled,
// otherwise passes the value through.
module shift_stage
   import iter_shifter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIST       = 1
) (
   input  logic [DATA_WIDTH-1:0] value_i,
   input  logic                  enable_i,
   input  logic [1:0]            op_i,
   output logic [DATA_WIDTH-1:0] value_o
);

   logic signed [DATA_WIDTH-1:0] value_s;

   assign value_s = value_i;

   always_comb begin
      value_o = value_i;
      if (enable_i) begin
         case (op_i)
            OP_SLL:  value_o = value_i << DIST;
            OP_SRL:  value_o = value_i >> DIST;
            // Arithmetic fill uses the current MSB, which each stage preserves.
            OP_SRA:  value_o = value_s >>> DIST;
            OP_ROR:  value_o = (value_i >> DIST) | (value_i << (DATA_WIDTH - DIST));
            default: value_o = value_i;
         endcase
      end
   end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator with valid/ready handshakes; consumes
// STAGES_PER_CYCLE shift-amount bits per SHIFT cycle, fixed latency N_ITER.
module iter_shifter
   import iter_shifter_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int STAGES_PER_CYCLE = 1,
   localparam int SHAMT_W         = shamt_w(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [SHAMT_W-1:0]    in_shamt,
   input  logic [1:0]            in_op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_zero
);

   localparam int N_ITER = (SHAMT_W + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
   localparam int CNT_W  = $clog2(N_ITER + 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] work_q, work_d;
   logic [SHAMT_W-1:0]    shamt_q, shamt_d;
   logic [1:0]            op_q, op_d;

   // All stages are chained; only the group selected by the counter is enabled,
   // the rest pass the working value through untouched.
   logic [DATA_WIDTH-1:0] chain [0:SHAMT_W];

   assign chain[0] = work_q;

   for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
      logic stage_en;
      assign stage_en = shamt_q[j] && (cnt_q == CNT_W'(j / STAGES_PER_CYCLE));
      shift_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .DIST       (1 << j)
      ) u_stage (
         .value_i  (chain[j]),
         .enable_i (stage_en),
         .op_i     (op_q),
         .value_o  (chain[j+1])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      shamt_d = shamt_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = in_a;
               shamt_d = in_shamt;
               op_d    = in_op;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            work_d = chain[SHAMT_W];
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_ITER - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   // Operand side-info only matters while SHIFT is active, so it needs no reset.
   always_ff @(posedge clk) begin
      shamt_q <= shamt_d;
      op_q    <= op_d;
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_result = work_q;
   assign out_zero   = (work_q == '0);

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: default 32-bit/1-stage instance and an
// 8-bit/3-stage instance sharing clock and reset.
module tb_iter_shifter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        iv0 = 1'b0, ir0, ov0, ordy0 = 1'b0, oz0;
   logic [31:0] a0 = '0, res0;
   logic [4:0]  sh0 = '0;
   logic [1:0]  op0 = '0;

   logic        iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0, oz1;
   logic [7:0]  a1 = '0, res1;
   logic [2:0]  sh1 = '0;
   logic [1:0]  op1 = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iter_shifter u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv0),
      .in_ready   (ir0),
      .in_a       (a0),
      .in_shamt   (sh0),
      .in_op      (op0),
      .out_valid  (ov0),
      .out_ready  (ordy0),
      .out_result (res0),
      .out_zero   (oz0)
   );

   iter_shifter #(
      .DATA_WIDTH       (8),
      .STAGES_PER_CYCLE (3)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv1),
      .in_ready   (ir1),
      .in_a       (a1),
      .in_shamt   (sh1),
      .in_op      (op1),
      .out_valid  (ov1),
      .out_ready  (ordy1),
      .out_result (res1),
      .out_zero   (oz1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic get_ov(input int d);
      return (d == 0) ? ov0 : ov1;
   endfunction

   function automatic logic get_ir(input int d);
      return (d == 0) ? ir0 : ir1;
   endfunction

   function automatic logic get_oz(input int d);
      return (d == 0) ? oz0 : oz1;
   endfunction

   function automatic logic [31:0] get_res(input int d);
      return (d == 0) ? res0 : {24'h0, res1};
   endfunction

   // Called 1 time unit after a rising edge; returns at the same phase.
   task automatic run(input int d, input logic [1:0] op, input logic [31:0] a,
                      input logic [4:0] sh, input logic [31:0] exp, input int exp_lat,
                      input string tag);
      int lat;
      if (d == 0) begin
         iv0 = 1'b1; op0 = op; a0 = a; sh0 = sh;
      end else begin
         iv1 = 1'b1; op1 = op; a1 = a[7:0]; sh1 = sh[2:0];
      end
      chk({tag, "_in_ready"}, {31'h0, get_ir(d)}, 32'h1);
      @(posedge clk); #1;
      iv0 = 1'b0; iv1 = 1'b0;
      lat = 0;
      while (!get_ov(d) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_result"}, get_res(d), exp);
      chk({tag, "_zero"}, {31'h0, get_oz(d)}, {31'h0, (exp == 32'h0)});
      if (d == 0) ordy0 = 1'b1; else ordy1 = 1'b1;
      @(posedge clk); #1;
      ordy0 = 1'b0; ordy1 = 1'b0;
      chk({tag, "_valid_cleared"}, {31'h0, get_ov(d)}, 32'h0);
      chk({tag, "_ready_again"}, {31'h0, get_ir(d)}, 32'h1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'h0, ov0}, 32'h0);
      chk("rst_out_result", res0, 32'h0);
      chk("rst_out_zero", {31'h0, oz0}, 32'h1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", {31'h0, ir0}, 32'h1);
      chk("post_rst_in_ready_w8", {31'h0, ir1}, 32'h1);

      run(0, 2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 5, "sra_neg");
      run(0, 2'b11, 32'h7F00_0000, 5'd4,  32'h07F0_0000, 5, "sra_pos");
      run(0, 2'b01, 32'h1234_5678, 5'd8,  32'h7812_3456, 5, "ror8");
      run(0, 2'b01, 32'h0000_0001, 5'd31, 32'h0000_0002, 5, "ror31");
      run(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, "sll31");
      run(0, 2'b10, 32'hF000_0000, 5'd28, 32'h0000_000F, 5, "srl28");
      run(0, 2'b00, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 5, "sll16");
      run(0, 2'b10, 32'h0000_0001, 5'd1,  32'h0000_0000, 5, "srl_to_zero");
      run(0, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 5, "sll_zero_amt");

      // Backpressure: hold DONE for 3 cycles while a stray request is offered.
      iv0 = 1'b1; op0 = 2'b10; a0 = 32'hA5A5_0000; sh0 = 5'd8;
      @(posedge clk); #1;
      iv0 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", {31'h0, ov0}, 32'h1);
         chk("bp_result", res0, 32'h00A5_A500);
         chk("bp_in_ready", {31'h0, ir0}, 32'h0);
         if (i == 1) begin
            iv0 = 1'b1; a0 = 32'h1111_1111; sh0 = 5'd0; op0 = 2'b00;
         end else begin
            iv0 = 1'b0;
         end
         @(posedge clk); #1;
      end
      iv0 = 1'b0;
      ordy0 = 1'b1;
      @(posedge clk); #1;
      ordy0 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("bp_no_capture_valid", {31'h0, ov0}, 32'h0);
         chk("bp_no_capture_ready", {31'h0, ir0}, 32'h1);
         @(posedge clk); #1;
      end
      chk("bp_result_kept", res0, 32'h00A5_A500);

      // Reset during the 2nd SHIFT cycle drops the request.
      iv0 = 1'b1; op0 = 2'b00; a0 = 32'h0000_00FF; sh0 = 5'd4;
      @(posedge clk); #1;
      iv0 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_valid", {31'h0, ov0}, 32'h0);
      chk("midrst_result", res0, 32'h0);
      chk("midrst_zero", {31'h0, oz0}, 32'h1);
      chk("midrst_in_ready", {31'h0, ir0}, 32'h1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_output", {31'h0, ov0}, 32'h0);
      end
      run(0, 2'b00, 32'h0000_00FF, 5'd4, 32'h0000_0FF0, 5, "after_rst");

      run(1, 2'b01, 32'h81, 5'd1, 32'hC0, 1, "w8_ror1");
      run(1, 2'b00, 32'h81, 5'd7, 32'h80, 1, "w8_sll7");
      run(1, 2'b11, 32'h81, 5'd7, 32'hFF, 1, "w8_sra7");
      run(1, 2'b10, 32'h81, 5'd3, 32'h10, 1, "w8_srl3");
      run(1, 2'b11, 32'hA5, 5'd0, 32'hA5, 1, "w8_sra_zero_amt");
      run(1, 2'b01, 32'h3C, 5'd0, 32'h3C, 1, "w8_ror_zero_amt");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
